regfile_port_arbiter: RTL and testbench

//  Shares the 2-read/1-write register file (ra1/ra2 -> rd1/rd2, we3/wa3/wd3) between two requesters A and B.

---
 rtl/regfile_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing a 2R/1W regfile between requesters A and B; one op per cycle, rsp 2 cycles after accept.
// Ready is a combinational grant; lock keeps the grant and a watchdog force-releases it; responses are never stalled.
module regfile_port_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_ra1,
  input  logic [AW-1:0] a_ra2,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rd1,
  output logic [DW-1:0] a_rd2,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_ra1,
  input  logic [AW-1:0] b_ra2,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rd1,
  output logic [DW-1:0] b_rd2,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          we3,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  state_t        r_state, w_state_nxt;
  logic          r_rr_b, w_rr_b_nxt;
  logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic          w_grant_a, w_grant_b;
  logic          w_acc_a, w_acc_b;

  logic          r_iss_vld;
  logic          r_iss_own_b;
  logic          r_iss_we;
  logic [AW-1:0] r_ra1, r_ra2, r_wa;
  logic [DW-1:0] r_wd;

  logic          r_a_rsp_vld, r_b_rsp_vld;
  logic [DW-1:0] r_a_rd1, r_a_rd2, r_b_rd1, r_b_rd2;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_b_nxt     = r_rr_b;
    w_lock_cnt_nxt = r_lock_cnt;
    w_grant_a      = 1'b0;
    w_grant_b      = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_valid && (!b_valid || !r_rr_b)) begin
          w_grant_a  = 1'b1;
          w_rr_b_nxt = 1'b1;
          if (a_lock) begin
            w_state_nxt    = LOCK_A;
            w_lock_cnt_nxt = CW'(1);
          end
        end else if (b_valid) begin
          w_grant_b  = 1'b1;
          w_rr_b_nxt = 1'b0;
          if (b_lock) begin
            w_state_nxt    = LOCK_B;
            w_lock_cnt_nxt = CW'(1);
          end
        end
      end
      LOCK_A: begin
        // Watchdog release takes the whole cycle: no grant to either side.
        if (r_lock_cnt == LOCK_MAX) begin
          w_state_nxt    = IDLE;
          w_rr_b_nxt     = 1'b1;
          w_lock_cnt_nxt = '0;
        end else if (a_valid) begin
          w_grant_a = 1'b1;
          if (a_lock) begin
            w_lock_cnt_nxt = r_lock_cnt + CW'(1);
          end else begin
            w_state_nxt    = IDLE;
            w_rr_b_nxt     = 1'b1;
            w_lock_cnt_nxt = '0;
          end
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        end
      end
      LOCK_B: begin
        if (r_lock_cnt == LOCK_MAX) begin
          w_state_nxt    = IDLE;
          w_rr_b_nxt     = 1'b0;
          w_lock_cnt_nxt = '0;
        end else if (b_valid) begin
          w_grant_b = 1'b1;
          if (b_lock) begin
            w_lock_cnt_nxt = r_lock_cnt + CW'(1);
          end else begin
            w_state_nxt    = IDLE;
            w_rr_b_nxt     = 1'b0;
            w_lock_cnt_nxt = '0;
          end
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  assign w_acc_a = w_grant_a & reset_n;
  assign w_acc_b = w_grant_b & reset_n;
  assign a_ready = w_acc_a;
  assign b_ready = w_acc_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rr_b     <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_b     <= w_rr_b_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Addresses/data hold their last value when no op is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_iss_vld   <= 1'b0;
      r_iss_own_b <= 1'b0;
      r_iss_we    <= 1'b0;
      r_ra1       <= '0;
      r_ra2       <= '0;
      r_wa        <= '0;
      r_wd        <= '0;
    end else begin
      r_iss_vld <= w_acc_a | w_acc_b;
      if (w_acc_a) begin
        r_iss_own_b <= 1'b0;
        r_iss_we    <= a_we;
        r_ra1       <= a_ra1;
        r_ra2       <= a_ra2;
        r_wa        <= a_wa;
        r_wd        <= a_wd;
      end else if (w_acc_b) begin
        r_iss_own_b <= 1'b1;
        r_iss_we    <= b_we;
        r_ra1       <= b_ra1;
        r_ra2       <= b_ra2;
        r_wa        <= b_wa;
        r_wd        <= b_wd;
      end
    end
  end

  assign ra1 = r_ra1;
  assign ra2 = r_ra2;
  assign wa3 = r_wa;
  assign wd3 = r_wd;
  // Gating with reset_n discards an in-flight write when reset lands mid-op.
  assign we3 = r_iss_vld & r_iss_we & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_rsp_vld <= 1'b0;
      r_b_rsp_vld <= 1'b0;
      r_a_rd1     <= '0;
      r_a_rd2     <= '0;
      r_b_rd1     <= '0;
      r_b_rd2     <= '0;
    end else begin
      r_a_rsp_vld <= r_iss_vld & ~r_iss_own_b;
      r_b_rsp_vld <= r_iss_vld & r_iss_own_b;
      if (r_iss_vld && !r_iss_own_b) begin
        r_a_rd1 <= rd1;
        r_a_rd2 <= rd2;
      end
      if (r_iss_vld && r_iss_own_b) begin
        r_b_rd1 <= rd1;
        r_b_rd2 <= rd2;
      end
    end
  end

  assign a_rsp_valid = r_a_rsp_vld;
  assign a_rd1       = r_a_rd1;
  assign a_rd2       = r_a_rd2;
  assign b_rsp_valid = r_b_rsp_vld;
  assign b_rd1       = r_b_rd1;
  assign b_rd2       = r_b_rd2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x32 regfile (R[i] starts at i*0x01010101).
module tb_regfile_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready, a_we, a_lock, a_rsp_valid;
  logic [4:0]  a_ra1, a_ra2, a_wa;
  logic [31:0] a_wd, a_rd1, a_rd2;
  logic        b_valid, b_ready, b_we, b_lock, b_rsp_valid;
  logic [4:0]  b_ra1, b_ra2, b_wa;
  logic [31:0] b_wd, b_rd1, b_rd2;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] wd3, rd1, rd2;
  logic        we3;

  logic [31:0] mem [32];
  bit          mem_init;
  int          n_chk, n_pass;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= i * 32'h01010101;
      mem_init <= 1'b1;
    end else if (we3) begin
      mem[wa3] <= wd3;
    end
  end
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

  regfile_port_arbiter #(.AW(5), .DW(32), .MAX_LOCK(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_lock(a_lock),
    .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa), .a_wd(a_wd),
    .a_rsp_valid(a_rsp_valid), .a_rd1(a_rd1), .a_rd2(a_rd2),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_lock(b_lock),
    .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa), .b_wd(b_wd),
    .b_rsp_valid(b_rsp_valid), .b_rd1(b_rd1), .b_rd2(b_rd2),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3), .we3(we3),
    .rd1(rd1), .rd2(rd2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic v, input logic we, input logic lk, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] w, input logic [31:0] d);
    a_valid = v; a_we = we; a_lock = lk; a_ra1 = r1; a_ra2 = r2; a_wa = w; a_wd = d;
  endtask

  task automatic req_b(input logic v, input logic we, input logic lk, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] w, input logic [31:0] d);
    b_valid = v; b_we = we; b_lock = lk; b_ra1 = r1; b_ra2 = r2; b_wa = w; b_wd = d;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset_n = 1'b0;
    req_a(1, 0, 0, 0, 0, 0, 0);
    req_b(1, 0, 0, 0, 0, 0, 0);

    // Reset held two cycles with both requesters valid
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_a_rsp", a_rsp_valid, 0);
      chk("rst_b_rsp", b_rsp_valid, 0);
      chk("rst_we3", we3, 0);
    end
    reset_n = 1'b1;
    #1;
    chk("first_grant_a", a_ready, 1);
    chk("first_grant_not_b", b_ready, 0);
    req_a(0, 0, 0, 0, 0, 0, 0);
    req_b(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Contention: grants A,B,A,B; each response pulse on its owner only
    for (int k = 0; k < 6; k++) begin
      req_a(k < 4, 0, 0, 1, 2, 0, 0);
      req_b(k < 4, 0, 0, 3, 4, 0, 0);
      #1;
      chk("rr_a_ready", a_ready, (k < 4) && (k % 2 == 0));
      chk("rr_b_ready", b_ready, (k < 4) && (k % 2 == 1));
      chk("rr_a_rsp", a_rsp_valid, (k >= 2) && (k % 2 == 0));
      chk("rr_b_rsp", b_rsp_valid, (k >= 2) && (k % 2 == 1));
      if (k >= 2 && k % 2 == 0) begin
        chk("rr_a_rd1", a_rd1, 32'h01010101);
        chk("rr_a_rd2", a_rd2, 32'h02020202);
      end
      if (k >= 2 && k % 2 == 1) begin
        chk("rr_b_rd1", b_rd1, 32'h03030303);
        chk("rr_b_rd2", b_rd2, 32'h04040404);
      end
      tick();
    end

    // Lock: A with lock=1,1,0 while B waits
    for (int k = 0; k < 4; k++) begin
      req_a(k < 3, 0, k < 2, 1, 2, 0, 0);
      req_b(1, 0, 0, 3, 4, 0, 0);
      #1;
      chk("lock_a_ready", a_ready, k < 3);
      chk("lock_b_ready", b_ready, k == 3);
      tick();
    end
    req_a(0, 0, 0, 0, 0, 0, 0);
    req_b(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Watchdog: A locks then idles; B gets the grant 9 cycles later
    req_a(1, 0, 1, 1, 2, 0, 0);
    req_b(1, 0, 0, 3, 4, 0, 0);
    #1;
    chk("wd_lock_grant_a", a_ready, 1);
    tick();
    req_a(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk("wd_b_ready", b_ready, k == 9);
      chk("wd_a_ready", a_ready, 0);
      tick();
    end
    req_b(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Write/read of R5 and same-op read-before-write
    req_a(1, 1, 0, 0, 0, 5, 32'hDEADBEEF);
    #1;
    chk("wr_a_ready", a_ready, 1);
    tick();
    chk("wr_we3", we3, 1);
    chk("wr_wa3", wa3, 5);
    chk("wr_wd3", wd3, 32'hDEADBEEF);
    req_a(1, 0, 0, 5, 5, 0, 0);
    #1;
    chk("rd_a_ready", a_ready, 1);
    tick();
    chk("wr_rsp", a_rsp_valid, 1);
    chk("rd_ra1", ra1, 5);
    chk("rd_we3", we3, 0);
    req_a(1, 1, 0, 5, 0, 5, 32'h00001234);
    tick();
    chk("rd_rsp", a_rsp_valid, 1);
    chk("rd_a_rd1", a_rd1, 32'hDEADBEEF);
    chk("rd_a_rd2", a_rd2, 32'hDEADBEEF);
    chk("rd_b_rsp", b_rsp_valid, 0);
    req_a(1, 0, 0, 0, 5, 0, 0);
    tick();
    chk("raw_rsp", a_rsp_valid, 1);
    chk("raw_old_value", a_rd1, 32'hDEADBEEF);
    req_a(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("new_rsp", a_rsp_valid, 1);
    chk("new_value", a_rd2, 32'h00001234);
    tick();
    chk("rsp_one_pulse", a_rsp_valid, 0);
    chk("idle_we3", we3, 0);

    // Reset the cycle after accepting a write of R3
    req_a(1, 1, 0, 0, 0, 3, 32'h00000055);
    #1;
    chk("mid_a_ready", a_ready, 1);
    tick();
    reset_n = 1'b0;
    req_a(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_we3", we3, 0);
    tick();
    chk("mid_rsp", a_rsp_valid, 0);
    chk("mid_r3_kept", mem[3], 32'h03030303);
    reset_n = 1'b1;
    tick();
    chk("mid_rsp_after", a_rsp_valid, 0);
    req_a(1, 0, 0, 3, 3, 0, 0);
    #1;
    chk("mid_read_ready", a_ready, 1);
    tick();
    req_a(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mid_read_rsp", a_rsp_valid, 1);
    chk("mid_read_r3", a_rd1, 32'h03030303);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
